// File: rtl/univ_shreg_pkg.sv
// univ_shreg_pkg
// Shared types for the universal shift register.
//   tShiftOp    : per-step operation code driven on the op port
//   tShregState : control FSM states (IDLE / RUN / DONE)
//   tMode141    : immediate vs. counted operating mode
//   is_single_step() : ops that complete in one step even when started as counted
package univ_shreg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_SHL   = 3'd1,
    OP_SHR   = 3'd2,
    OP_ROTL  = 3'd3,
    OP_ROTR  = 3'd4,
    OP_ASHR  = 3'd5,
    OP_HOLD  = 3'd6,
    OP_CLEAR = 3'd7
  } tShiftOp;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tShregState;

  typedef enum logic {
    MODE_IMMEDIATE = 1'b0,
    MODE_COUNTED   = 1'b1
  } tMode141;

  // LOAD, HOLD and CLEAR give the same result however often they repeat,
  // so a counted request for them collapses to one step.
  function automatic logic is_single_step(input tShiftOp op);
    return (op == OP_LOAD) || (op == OP_HOLD) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/univ_shreg_if.sv
// univ_shreg_if
// Bus bundle between a controller and univ_shreg.
//   op, d, shft_in_l, shft_in_r, start, count : controller -> register
//   q, shft_out_l, shft_out_r, busy, done      : register -> controller
// Bit 0 of d/q is the MSB (left end), bit WIDTH-1 the LSB (right end).
interface univ_shreg_if #(
  parameter int WIDTH = 36,
  parameter int CNTW  = 6
);
  import univ_shreg_pkg::*;

  tShiftOp          op;
  logic [0:WIDTH-1] d;
  logic             shft_in_l;
  logic             shft_in_r;
  logic             start;
  logic [CNTW-1:0]  count;
  logic [0:WIDTH-1] q;
  logic             shft_out_l;
  logic             shft_out_r;
  logic             busy;
  logic             done;

  modport master (
    output op, d, shft_in_l, shft_in_r, start, count,
    input  q, shft_out_l, shft_out_r, busy, done
  );

  modport slave (
    input  op, d, shft_in_l, shft_in_r, start, count,
    output q, shft_out_l, shft_out_r, busy, done
  );

endinterface

// File: rtl/univ_shreg_shift_step.sv
// univ_shreg_shift_step
// Combinational next-value function for one step of the shift register.
//   i_op        : operation to apply
//   i_q         : current register contents ([0] = MSB)
//   i_d         : parallel load data
//   i_shft_in_l : bit entering at the left end on SHR
//   i_shft_in_r : bit entering at the right end on SHL
//   o_q         : register contents after the step
module univ_shreg_shift_step
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  tShiftOp          i_op,
  input  logic [0:WIDTH-1] i_q,
  input  logic [0:WIDTH-1] i_d,
  input  logic             i_shft_in_l,
  input  logic             i_shft_in_r,
  output logic [0:WIDTH-1] o_q
);

  always_comb begin
    o_q = i_q;
    case (i_op)
      OP_LOAD:  o_q = i_d;
      OP_SHL:   o_q = {i_q[1:WIDTH-1], i_shft_in_r};
      OP_SHR:   o_q = {i_shft_in_l, i_q[0:WIDTH-2]};
      OP_ROTL:  o_q = {i_q[1:WIDTH-1], i_q[0]};
      OP_ROTR:  o_q = {i_q[WIDTH-1], i_q[0:WIDTH-2]};
      // Left end is the sign bit, so it is replicated.
      OP_ASHR:  o_q = {i_q[0], i_q[0:WIDTH-2]};
      OP_HOLD:  o_q = i_q;
      OP_CLEAR: o_q = '0;
      default:  o_q = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shreg.sv
// univ_shreg
// Universal shift register with immediate single-step mode and a counted
// multi-step mode sequenced by an IDLE/RUN/DONE FSM.
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-high reset (clears q and aborts any run)
//   bus   : univ_shreg_if slave port
//     op/d/shft_in_l/shft_in_r : step operation, load data, serial inputs
//     start/count              : request a counted operation of count steps
//     q, shft_out_l/r          : contents and its end bits
//     busy                     : high while stepping in RUN
//     done                     : one-cycle completion pulse (DONE state)
module univ_shreg
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNTW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  univ_shreg_if.slave     bus
);

  tShregState       r_state;
  tShiftOp          r_op;
  logic [CNTW-1:0]  r_rem;
  logic [0:WIDTH-1] r_q;

  tShregState       w_state_nxt;
  tShiftOp          w_op_nxt;
  logic [CNTW-1:0]  w_rem_nxt;
  logic [0:WIDTH-1] w_q_nxt;
  tShiftOp          w_step_op;
  logic [0:WIDTH-1] w_q_step;

  // RUN steps with the op captured at start; live op is ignored there.
  assign w_step_op = (r_state == ST_RUN) ? r_op : bus.op;

  univ_shreg_shift_step #(.WIDTH(WIDTH)) u_step (
    .i_op        (w_step_op),
    .i_q         (r_q),
    .i_d         (bus.d),
    .i_shft_in_l (bus.shft_in_l),
    .i_shft_in_r (bus.shft_in_r),
    .o_q         (w_q_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_rem   <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    case (r_state)
      ST_IDLE: begin
        if (!bus.start) begin
          w_q_nxt = w_q_step;
        end else begin
          w_op_nxt = bus.op;
          if (is_single_step(bus.op)) begin
            w_q_nxt     = w_q_step;
            w_rem_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else if (bus.count == '0) begin
            w_rem_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            // q is left alone on the start edge; stepping begins next edge.
            w_rem_nxt   = bus.count;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_q_nxt   = w_q_step;
        w_rem_nxt = r_rem - 1'b1;
        if (r_rem == CNTW'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.q          = r_q;
  assign bus.shft_out_l = r_q[0];
  assign bus.shft_out_r = r_q[WIDTH-1];
  assign bus.busy       = (r_state == ST_RUN);
  assign bus.done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_univ_shreg.sv
module tb_univ_shreg;
  import univ_shreg_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int WD = 36;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  univ_shreg_if #(.WIDTH(W), .CNTW(CW)) bus ();
  univ_shreg_if bus_d ();

  univ_shreg #(.WIDTH(W), .CNTW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  univ_shreg dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of the register and its control sequence.
  logic [0:W-1]    m_q;
  int              m_st;   // 0 idle, 1 run, 2 done
  tShiftOp         m_op;
  int              m_rem;

  typedef struct {
    logic [0:W-1] q;
    logic         busy;
    logic         done;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [0:W-1] mstep(input tShiftOp o, input logic [0:W-1] q,
                                         input logic [0:W-1] dv, input logic l, input logic r);
    case (o)
      OP_LOAD:  return dv;
      OP_SHL:   return {q[1:W-1], r};
      OP_SHR:   return {l, q[0:W-2]};
      OP_ROTL:  return {q[1:W-1], q[0]};
      OP_ROTR:  return {q[W-1], q[0:W-2]};
      OP_ASHR:  return {q[0], q[0:W-2]};
      OP_CLEAR: return '0;
      default:  return q;
    endcase
  endfunction

  task automatic model_reset();
    m_q = '0; m_st = 0; m_op = OP_HOLD; m_rem = 0;
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
  task automatic cyc(input tShiftOp o, input logic [0:W-1] dv, input logic st,
                     input logic [CW-1:0] cnt, input logic sl, input logic sr);
    exp_t e;
    bus.op = o; bus.d = dv; bus.start = st; bus.count = cnt;
    bus.shft_in_l = sl; bus.shft_in_r = sr;
    case (m_st)
      0: begin
        if (!st) m_q = mstep(o, m_q, dv, sl, sr);
        else begin
          m_op = o;
          if (o == OP_LOAD || o == OP_HOLD || o == OP_CLEAR) begin
            m_q = mstep(o, m_q, dv, sl, sr); m_st = 2;
          end else if (cnt == 0) m_st = 2;
          else begin m_rem = int'(cnt); m_st = 1; end
        end
      end
      1: begin
        m_q = mstep(m_op, m_q, dv, sl, sr);
        m_rem--;
        if (m_rem == 0) m_st = 2;
      end
      default: m_st = 0;
    endcase
    e.q = m_q; e.busy = (m_st == 1); e.done = (m_st == 2);
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("q", 64'(bus.q), 64'(e.q));
    chk("busy", 64'(bus.busy), 64'(e.busy));
    chk("done", 64'(bus.done), 64'(e.done));
    chk("shft_out_r", 64'(bus.shft_out_r), 64'(e.q[W-1]));
    chk("shft_out_l", 64'(bus.shft_out_l), 64'(e.q[0]));
  endtask

  task automatic idle();
    cyc(OP_HOLD, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [0:7] serial_bits;

  initial begin
    reset = 1'b1;
    bus.op = OP_HOLD; bus.d = '0; bus.start = 1'b0; bus.count = '0;
    bus.shft_in_l = 1'b0; bus.shft_in_r = 1'b0;
    bus_d.op = OP_HOLD; bus_d.d = '0; bus_d.start = 1'b0; bus_d.count = '0;
    bus_d.shft_in_l = 1'b0; bus_d.shft_in_r = 1'b0;
    model_reset();
    #12;
    chk("rst_q", 64'(bus.q), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_q_default", 64'(bus_d.q), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Immediate mode
    cyc(OP_LOAD, 8'hA5, 1'b0, '0, 1'b0, 1'b0);
    cyc(OP_SHL, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("imm_q", 64'(bus.q), 64'h4B);
    chk("imm_busy", 64'(bus.busy), 64'h0);
    chk("imm_done", 64'(bus.done), 64'h0);

    // Counted ROTR by 3
    cyc(OP_LOAD, 8'h81, 1'b0, '0, 1'b0, 1'b0);
    cyc(OP_ROTR, '0, 1'b1, 4'd3, 1'b0, 1'b0);
    chk("rotr_start_q", 64'(bus.q), 64'h81);
    chk("rotr_busy", 64'(bus.busy), 64'h1);
    for (int i = 0; i < 3; i++) idle();
    chk("rotr_q", 64'(bus.q), 64'h30);
    chk("rotr_done", 64'(bus.done), 64'h1);
    idle();
    chk("rotr_idle_done", 64'(bus.done), 64'h0);

    // ASHR by 2, then count 0
    cyc(OP_LOAD, 8'h90, 1'b0, '0, 1'b0, 1'b0);
    cyc(OP_ASHR, '0, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(); idle();
    chk("ashr_q", 64'(bus.q), 64'hE4);
    idle();
    cyc(OP_ASHR, '0, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("cnt0_done", 64'(bus.done), 64'h1);
    chk("cnt0_busy", 64'(bus.busy), 64'h0);
    chk("cnt0_q", 64'(bus.q), 64'hE4);
    idle();

    // Inputs during RUN are ignored
    cyc(OP_LOAD, 8'hFF, 1'b0, '0, 1'b0, 1'b0);
    cyc(OP_SHL, '0, 1'b1, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(OP_LOAD, 8'h00, i[0], 4'd9, 1'b0, 1'b0);
    chk("ign_q", 64'(bus.q), 64'hF0);
    chk("ign_done", 64'(bus.done), 64'h1);
    cyc(OP_LOAD, 8'h00, 1'b1, 4'd9, 1'b0, 1'b0);  // start in DONE is ignored
    chk("ign_done_q", 64'(bus.q), 64'hF0);

    // Asynchronous reset mid-RUN
    cyc(OP_LOAD, 8'h3C, 1'b0, '0, 1'b0, 1'b0);
    cyc(OP_ROTL, '0, 1'b1, 4'd5, 1'b0, 1'b0);
    idle(); idle();
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_q", 64'(bus.q), 64'h0);
    chk("arst_busy", 64'(bus.busy), 64'h0);
    chk("arst_done", 64'(bus.done), 64'h0);
    @(posedge clk); #1;
    chk("arst_hold_q", 64'(bus.q), 64'h0);
    reset = 1'b0;
    idle();
    chk("arst_no_done", 64'(bus.done), 64'h0);
    idle();

    // Serial stream through SHR
    serial_bits = 8'b1011_0010;
    cyc(OP_SHR, '0, 1'b1, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(OP_HOLD, '0, 1'b0, '0, serial_bits[i], 1'b0);
    chk("ser_q", 64'(bus.q), 64'h4D);
    chk("ser_done", 64'(bus.done), 64'h1);
    idle();

    // Default-parameter build
    bus_d.op = OP_LOAD; bus_d.d = 36'h8_0000_0001;
    @(posedge clk); #1;
    chk("def_load", 64'(bus_d.q), 64'h8_0000_0001);
    bus_d.op = OP_ROTL;
    @(posedge clk); #1;
    chk("def_rotl", 64'(bus_d.q), 64'h0_0000_0003);
    bus_d.op = OP_ROTR; bus_d.start = 1'b1; bus_d.count = 6'd1;
    @(posedge clk); #1;
    chk("def_busy", 64'(bus_d.busy), 64'h1);
    bus_d.op = OP_HOLD; bus_d.start = 1'b0;
    @(posedge clk); #1;
    chk("def_done", 64'(bus_d.done), 64'h1);
    chk("def_rotr", 64'(bus_d.q), 64'h8_0000_0001);
    chk("def_out_l", 64'(bus_d.shft_out_l), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog: bench is short; anything beyond this means it is stuck.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
